seq_gen_controller: RTL and testbench
=====================================

// Module: seq_gen_controller
// PURPOSE
//  Sequences the shift-register sequence generator. Loads a seed, then steps the
//  WIDTH-bit right-shifting register (D[i]=Q[i+1]) once per accepted output beat.
//  Operating modes are plain rotation or Fibonacci LFSR. Streams Q[0] to a
//  consumer over a valid/ready handshake for a programmed number of beats, then
//  pulses done. Sits between the control/CPU side (start/seed/run_len) and the
//  serial consumer.
// PARAMETERS
//  WIDTH  3       shift-register width (>=2)
//  LEN_W  8       width of run_len and beat counter; max run = 2^LEN_W-1 beats
//  TAPS   3'b011  LFSR tap mask (WIDTH bits); fb = ^(shreg & TAPS)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      start request; sampled only in IDLE
//  seed       in   WIDTH  initial register value, latched on accepted start
//  run_len    in   LEN_W  number of beats to emit, latched on accepted start
//  mode       in   1      0 = rotate, 1 = LFSR; latched on accepted start
//  abort      in   1      cancel an active run (RUN state only)
//  out_ready  in   1      consumer ready
//  out_valid  out  1      out_bit valid
//  out_bit    out  1      current generator bit = shreg[0]
//  busy       out  1      high in RUN
//  done       out  1      one-cycle pulse on normal completion
//  shreg_q    out  WIDTH  current register contents (debug/readback)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-run): state=IDLE, shreg=0, count=0.
//    All outputs 0 while reset is high and after its release.
//  - States: IDLE, RUN, DONE. Registered outputs are decoded from state.
//  - IDLE: start=1 & run_len!=0 -> shreg<=seed, len<=run_len, mode latched,
//    count<=0, next=RUN. out_valid rises the cycle after start (latency 1).
//  - IDLE: start=1 & run_len==0 -> next=DONE. No beat is emitted.
//  - LFSR lock-up guard: mode=1 & seed==0 -> shreg loads {0..0,1} instead.
//  - RUN: out_valid=1, busy=1, out_bit=shreg[0].
//    Beat = out_valid & out_ready. On a beat:
//      rotate: shreg<={shreg[0], shreg[WIDTH-1:1]}
//      LFSR:   shreg<={^(shreg&TAPS), shreg[WIDTH-1:1]}
//    Each beat increments count.
//  - Backpressure: with out_ready=0, shreg, count and out_bit hold stable and
//    out_valid stays 1. No combinational path from out_ready to out_valid.
//  - Last beat (beat while count==len-1) -> next=DONE. The register still shifts,
//    so shreg_q holds the post-run value.
//  - DONE: done=1 for exactly one cycle, out_valid=0, busy=0, then IDLE.
//    A start that arrives in DONE is ignored.
//  - start is ignored in RUN/DONE; seed, run_len and mode are not re-sampled.
//  - abort in RUN -> next=IDLE, no done pulse, register not shifted.
//    abort beats a simultaneous beat: that beat is discarded and not counted.
//    abort has no effect in IDLE or DONE.
//  - Back-to-back: start asserted the cycle after the done pulse (IDLE) is
//    accepted normally.
//  - shreg retains its value across IDLE until the next accepted start.
// TESTING
//  1 rotate: seed=101, run_len=6, out_ready=1 -> out_bit 1,0,1,1,0,1 on 6
//    consecutive cycles starting 1 cycle after start; done pulses the next
//    cycle; shreg_q=101.
//  2 LFSR (TAPS=011): seed=001, run_len=7 -> out_bit 1,0,0,1,0,1,1;
//    shreg_q=001 at done (period 7).
//  3 backpressure: test 1 with out_ready=0 for 3 cycles after beat 2 -> out_bit=1
//    and out_valid=1 held, same 6-bit sequence, done delayed 3 cycles.
//  4 lock-up: mode=1, seed=000, run_len=7 -> identical to test 2.
//  5 abort: raise abort with out_ready=1 during beat 3 of test 1 -> only 2 beats
//    counted, IDLE next cycle, no done. A following start with run_len=2 emits 2
//    beats and pulses done.
//  6 edges: run_len=0 -> done 1 cycle after start, out_valid never 1. Async reset
//    pulse mid-run -> outputs 0 immediately, no done.

Source files
------------

// File: rtl/seq_gen_controller.sv
// seq_gen_controller: sequences a WIDTH-bit right-shifting generator register
// (rotate or Fibonacci LFSR) and streams shreg[0] over a valid/ready handshake
// for a programmed number of beats, then pulses done for one cycle.
module seq_gen_controller #(
    parameter int unsigned     WIDTH = 3,
    parameter int unsigned     LEN_W = 8,
    parameter logic [WIDTH-1:0] TAPS = 3'b011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] run_len,
    input  logic             mode,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shreg_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len;
    logic             mode_q;

    // Bit shifted into the MSB on a beat: wrap-around of bit 0, or LFSR feedback
    logic             shift_in_c;
    // Last beat is the one taken while count == len-1
    logic             last_beat_c;
    // Seed as loaded; an all-zero LFSR seed would lock up, so force a single 1
    logic [WIDTH-1:0] load_val_c;

    // Shift-in bit for the active mode
    always_comb begin
        shift_in_c = shreg[0];
        if (mode_q) begin
            shift_in_c = ^(shreg & TAPS);
        end
    end

    // Terminal-count compare
    always_comb begin
        last_beat_c = (count == (len - LEN_W'(1)));
    end

    // Seed selection with LFSR lock-up guard
    always_comb begin
        load_val_c = seed;
        if (mode && (seed == '0)) begin
            load_val_c = WIDTH'(1);
        end
    end

    // Controller FSM plus generator register, beat counter and latched run setup
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            len    <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (run_len != '0) begin
                            shreg  <= load_val_c;
                            len    <= run_len;
                            mode_q <= mode;
                            count  <= '0;
                            state  <= RUN;
                        end else begin
                            state  <= DONE;
                        end
                    end
                end
                RUN: begin
                    // abort wins over a simultaneous beat: nothing shifts or counts
                    if (abort) begin
                        state <= IDLE;
                    end else if (out_ready) begin
                        shreg <= {shift_in_c, shreg[WIDTH-1:1]};
                        count <= count + LEN_W'(1);
                        if (last_beat_c) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded straight from flops; out_ready never reaches out_valid
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign out_bit   = shreg[0];
    assign shreg_q   = shreg;

endmodule

// File: tb/tb_seq_gen_controller.sv
// Directed bench for seq_gen_controller: rotate, LFSR, backpressure, lock-up
// guard, abort, zero-length run, start-in-DONE, back-to-back and async reset.
module tb_seq_gen_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] seed;
    logic [7:0] run_len;
    logic       mode;
    logic       abort;
    logic       out_ready;
    logic       out_valid;
    logic       out_bit;
    logic       busy;
    logic       done;
    logic [2:0] shreg_q;

    int errors;
    int checks;

    seq_gen_controller #(
        .WIDTH(3),
        .LEN_W(8),
        .TAPS (3'b011)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .seed     (seed),
        .run_len  (run_len),
        .mode     (mode),
        .abort    (abort),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_bit  (out_bit),
        .busy     (busy),
        .done     (done),
        .shreg_q  (shreg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; seed = '0; run_len = '0; mode = 1'b0;
        abort = 1'b0; out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_bit, busy, done, shreg_q} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold: outs=%b required 0000000",
                     {out_valid, out_bit, busy, done, shreg_q});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({out_valid, out_bit, busy, done, shreg_q} !== 7'b0) begin
            errors++;
            $display("FAIL reset_release: outs=%b required 0000000",
                     {out_valid, out_bit, busy, done, shreg_q});
        end
    endtask

    // seed 101 rotate, 6 beats, optional 3-cycle stall after beat 2
    task automatic test_rotate(input bit stall);
        logic [5:0] exp_bits;
        exp_bits = 6'b101101; // index 5 is the first beat
        start = 1'b1; seed = 3'b101; run_len = 8'd6; mode = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (stall && k == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    checks++;
                    if (out_valid !== 1'b1 || out_bit !== 1'b1 || busy !== 1'b1 || shreg_q !== 3'b011) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: valid=%b bit=%b busy=%b shreg=%b required 1 1 1 011",
                                 s, out_valid, out_bit, busy, shreg_q);
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_bit !== exp_bits[5-k]) begin
                errors++;
                $display("FAIL rotate_beat[%0d]: valid=%b bit=%b required 1 %b",
                         k, out_valid, out_bit, exp_bits[5-k]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || shreg_q !== 3'b101) begin
            errors++;
            $display("FAIL rotate_done: done=%b valid=%b busy=%b shreg=%b required 1 0 0 101",
                     done, out_valid, busy, shreg_q);
        end
        step();
        checks++;
        if (done !== 1'b0 || shreg_q !== 3'b101) begin
            errors++;
            $display("FAIL rotate_after_done: done=%b shreg=%b required 0 101", done, shreg_q);
        end
    endtask

    // TAPS=011 LFSR, 7 beats; seed 000 must behave like seed 001
    task automatic test_lfsr(input logic [2:0] s);
        logic [6:0] exp_bits;
        exp_bits = 7'b1001011; // index 6 is the first beat
        start = 1'b1; seed = s; run_len = 8'd7; mode = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_bit !== exp_bits[6-k]) begin
                errors++;
                $display("FAIL lfsr_beat[seed=%b,%0d]: valid=%b bit=%b required 1 %b",
                         s, k, out_valid, out_bit, exp_bits[6-k]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || shreg_q !== 3'b001) begin
            errors++;
            $display("FAIL lfsr_done[seed=%b]: done=%b shreg=%b required 1 001", s, done, shreg_q);
        end
        step();
    endtask

    task automatic test_abort();
        start = 1'b1; seed = 3'b101; run_len = 8'd6; mode = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || shreg_q !== 3'b011) begin
            errors++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b shreg=%b required 0 0 0 011",
                     out_valid, busy, done, shreg_q);
        end
        step();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b valid=%b required 0 0", done, out_valid);
        end
        start = 1'b1; run_len = 8'd2;
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun_b0: valid=%b bit=%b required 1 1", out_valid, out_bit);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b0) begin
            errors++;
            $display("FAIL abort_rerun_b1: valid=%b bit=%b required 1 0", out_valid, out_bit);
        end
        step();
        checks++;
        if (done !== 1'b1 || shreg_q !== 3'b011) begin
            errors++;
            $display("FAIL abort_rerun_done: done=%b shreg=%b required 1 011", done, shreg_q);
        end
        step();
    endtask

    // run_len=0 goes straight to DONE; a start held into DONE is ignored
    task automatic test_zero_len();
        start = 1'b1; seed = 3'b110; run_len = 8'd0; mode = 1'b0;
        step();
        run_len = 8'd5;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b valid=%b busy=%b required 1 0 0",
                     done, out_valid, busy);
        end
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: done=%b valid=%b busy=%b required 0 0 0",
                     done, out_valid, busy);
        end
        step();
    endtask

    // Start issued in the IDLE cycle right after a done pulse
    task automatic test_back_to_back();
        start = 1'b1; seed = 3'b010; run_len = 8'd1; mode = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (done !== 1'b1 || shreg_q !== 3'b001) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b shreg=%b required 1 001", done, shreg_q);
        end
        step();
        start = 1'b1; seed = 3'b011;
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1 || shreg_q !== 3'b011) begin
            errors++;
            $display("FAIL b2b_accept: valid=%b bit=%b shreg=%b required 1 1 011",
                     out_valid, out_bit, shreg_q);
        end
        step();
        checks++;
        if (done !== 1'b1 || shreg_q !== 3'b101) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b shreg=%b required 1 101", done, shreg_q);
        end
        step();
    endtask

    task automatic test_async_reset();
        start = 1'b1; seed = 3'b111; run_len = 8'd6; mode = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_bit, busy, done, shreg_q} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset_now: outs=%b required 0000000",
                     {out_valid, out_bit, busy, done, shreg_q});
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || shreg_q !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_after: done=%b valid=%b shreg=%b required 0 0 000",
                     done, out_valid, shreg_q);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_done: done=%b required 0", done);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_rotate(1'b0);
        test_lfsr(3'b001);
        test_rotate(1'b1);
        test_lfsr(3'b000);
        test_abort();
        test_zero_len();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
